// File: rtl/pal_macrocell_array_if.sv
// Bus bundle for pal_macrocell_array: serial config chain, run control,
// PAL input variables and outputs.
//   master : drives cfg_en, cfg_in, cfg_commit, run, in_vars; observes the rest
//   slave  : the PAL itself; drives cfg_out, cfg_valid, cfg_err, out_vals
interface pal_macrocell_array_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 6
);
  logic         cfg_en;
  logic         cfg_in;
  logic         cfg_commit;
  logic         run;
  logic [N-1:0] in_vars;
  logic         cfg_out;
  logic         cfg_valid;
  logic         cfg_err;
  logic [M-1:0] out_vals;

  modport master (
    output cfg_en, cfg_in, cfg_commit, run, in_vars,
    input  cfg_out, cfg_valid, cfg_err, out_vals
  );

  modport slave (
    input  cfg_en, cfg_in, cfg_commit, run, in_vars,
    output cfg_out, cfg_valid, cfg_err, out_vals
  );
endinterface

// File: rtl/pal_macrocell_array.sv
// Programmable AND/OR array with one macrocell per output.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   res_n  : asynchronous active-low reset
//   bus    : pal_macrocell_array_if slave (config chain, run, in_vars, outputs)
// Config word layout (active word c, W = 2*(N+M)):
//   c[p*W + 2k]   enables literal v[k], c[p*W + 2k+1] enables ~v[k], v = {fb, in_vars}
//   c[A + m*P + p] connects term p to sum m (A = P*W)
//   c[B + 2m] = reg_mode, c[B + 2m+1] = invert (B = A + M*P)
module pal_macrocell_array #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 6,
  parameter int unsigned P = 11
) (
  input logic                    clk,
  input logic                    res_n,
  pal_macrocell_array_if.slave   bus
);
  localparam int unsigned W        = 2 * (N + M);
  localparam int unsigned A        = P * W;
  localparam int unsigned B        = A + M * P;
  localparam int unsigned CFG_BITS = B + 2 * M;
  localparam int unsigned CntW     = $clog2(CFG_BITS + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(CFG_BITS);
  localparam logic [CntW-1:0] CntSat  = CntW'(CFG_BITS + 1);

  logic [CFG_BITS-1:0] shift_q, active_q;
  logic [CntW-1:0]     cnt_q;
  logic                valid_q, err_q;
  logic [M-1:0]        flop_q;

  logic [N+M-1:0] v;
  logic [P-1:0]   terms;
  logic [M-1:0]   sums;
  logic [M-1:0]   outs;
  logic           accept, reject;

  // Feedback is taken only from the flops, so the array is loop-free.
  always_comb begin
    logic t;
    logic any;
    v     = {flop_q, bus.in_vars};
    terms = '0;
    for (int p = 0; p < int'(P); p++) begin
      t   = 1'b1;
      any = 1'b0;
      for (int k = 0; k < int'(N + M); k++) begin
        if (active_q[p*W + 2*k]) begin
          t   = t & v[k];
          any = 1'b1;
        end
        if (active_q[p*W + 2*k + 1]) begin
          t   = t & ~v[k];
          any = 1'b1;
        end
      end
      // A term with no literals is 0, not the empty-AND value of 1.
      terms[p] = t & any;
    end
  end

  always_comb begin
    sums = '0;
    outs = '0;
    for (int m = 0; m < int'(M); m++) begin
      sums[m] = |(terms & active_q[A + m*P +: P]);
      outs[m] = (active_q[B + 2*m] ? flop_q[m] : sums[m]) ^ active_q[B + 2*m + 1];
    end
  end

  assign accept = bus.cfg_commit & ~bus.cfg_en & (cnt_q == CntFull);
  assign reject = bus.cfg_commit & ~accept;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      shift_q  <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      flop_q   <= '0;
    end else begin
      if (bus.cfg_en) begin
        shift_q <= {shift_q[CFG_BITS-2:0], bus.cfg_in};
      end
      if (bus.cfg_commit) begin
        cnt_q <= '0;
      end else if (bus.cfg_en && cnt_q != CntSat) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept) begin
        active_q <= shift_q;
        valid_q  <= 1'b1;
      end
      err_q <= reject;
      // A fresh config always starts from cleared macrocells.
      if (accept) begin
        flop_q <= '0;
      end else if (bus.run && valid_q) begin
        flop_q <= sums;
      end
    end
  end

  assign bus.cfg_out   = shift_q[CFG_BITS-1];
  assign bus.cfg_valid = valid_q;
  assign bus.cfg_err   = err_q;
  assign bus.out_vals  = valid_q ? outs : '0;
endmodule

// File: tb/tb_pal_macrocell_array.sv
// Scoreboard bench for pal_macrocell_array with N=2, M=1, P=2 (16 config bits).
// Observation vector per check: {cfg_out, cfg_err, cfg_valid, out_vals[0]}.
module tb_pal_macrocell_array;
  logic clk;
  logic res_n;

  pal_macrocell_array_if #(.N(2), .M(1)) bus ();

  pal_macrocell_array #(.N(2), .M(1), .P(2)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] mask;
    logic [3:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [3:0] MAll = 4'b1111;
  localparam logic [3:0] MEvo = 4'b0111;  // err, valid, out
  localparam logic [3:0] MOut = 4'b0001;
  localparam logic [3:0] MRb  = 4'b1011;  // cfg_out, valid, out

  exp_t       e_mon;
  logic [3:0] obs_mon;

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e_mon   = sb.pop_front();
      obs_mon = {bus.cfg_out, bus.cfg_err, bus.cfg_valid, bus.out_vals[0]};
      checks++;
      if ((obs_mon & e_mon.mask) !== (e_mon.exp & e_mon.mask)) begin
        errors++;
        $display("FAIL %s: got %b want %b (mask %b)", e_mon.name, obs_mon, e_mon.exp,
                 e_mon.mask);
      end
    end
  end

  task automatic expect_obs(input string name, input logic [3:0] mask, input logic [3:0] exp);
    exp_t e;
    e.name = name;
    e.mask = mask;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus.cfg_en = 1'b1;
      bus.cfg_in = w[15-i];
      tick();
    end
    bus.cfg_en = 1'b0;
    bus.cfg_in = 1'b0;
  endtask

  task automatic commit_pulse();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
  endtask

  task automatic load(input logic [15:0] w);
    shift_bits(w, 16);
    commit_pulse();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rb;
    logic [1:0]  ab;
    res_n          = 1'b0;
    bus.cfg_en     = 1'b0;
    bus.cfg_in     = 1'b0;
    bus.cfg_commit = 1'b0;
    bus.run        = 1'b0;
    bus.in_vars    = 2'b00;
    tick();
    expect_obs("reset_state", MAll, 4'b0000);
    tick();
    res_n = 1'b1;
    tick();

    // 1: AND of the two inputs, combinational.
    load(16'h1005);
    expect_obs("and_commit", 4'b0110, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      ab          = 2'(i);
      bus.in_vars = ab;
      expect_obs("and_truth", MOut, {3'b000, ab[0] & ab[1]});
      tick();
    end

    // 2: short and long loads are rejected.
    bus.in_vars = 2'b11;
    shift_bits(16'hFFFF, 15);
    commit_pulse();
    expect_obs("short_err", MEvo, 4'b0111);
    tick();
    expect_obs("short_err_end", MEvo, 4'b0011);
    tick();
    shift_bits(16'h0000, 16);
    shift_bits(16'h0000, 1);
    commit_pulse();
    expect_obs("long_err", MEvo, 4'b0111);
    tick();
    expect_obs("long_err_end", MEvo, 4'b0011);
    tick();

    // 3: registered toggle through ~fb0.
    bus.in_vars = 2'b00;
    load(16'h5020);
    expect_obs("tog_commit", MEvo, 4'b0010);
    bus.run = 1'b1;
    tick();
    expect_obs("tog_1", MOut, 4'b0001);
    tick();
    expect_obs("tog_2", MOut, 4'b0000);
    tick();
    expect_obs("tog_3", MOut, 4'b0001);
    bus.run = 1'b0;
    tick();
    expect_obs("hold_1", MOut, 4'b0001);
    tick();
    expect_obs("hold_2", MOut, 4'b0001);
    bus.run = 1'b1;
    tick();
    expect_obs("tog_4", MOut, 4'b0000);
    bus.run = 1'b0;
    shift_bits(16'h5020, 16);
    bus.run = 1'b1;
    commit_pulse();
    expect_obs("commit_clear_wins", MEvo, 4'b0010);
    tick();
    expect_obs("tog_after_clear", MOut, 4'b0001);
    bus.run = 1'b0;
    tick();

    // 4: NAND via invert; commit during shift is rejected.
    bus.in_vars = 2'b00;
    load(16'h9005);
    expect_obs("nand_commit", MEvo, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      ab          = 2'(i);
      bus.in_vars = ab;
      expect_obs("nand_truth", MOut, {3'b000, ~(ab[0] & ab[1])});
      tick();
    end
    bus.in_vars = 2'b11;
    shift_bits(16'h1005, 16);
    bus.cfg_en = 1'b1;
    bus.cfg_in = 1'b0;
    commit_pulse();
    bus.cfg_en = 1'b0;
    expect_obs("commit_during_shift", MEvo, 4'b0110);
    tick();

    // 5: reset mid-shift, then a fresh load.
    shift_bits(16'hAAAA, 8);
    res_n = 1'b0;
    #1;
    expect_obs("mid_reset", MAll, 4'b0000);
    tick();
    res_n = 1'b1;
    tick();
    load(16'h1005);
    expect_obs("reload_after_reset", MEvo, 4'b0011);
    tick();

    // 6: readback of the last shifted word, active config untouched.
    rb = 16'h1005;
    for (int i = 0; i < 16; i++) begin
      expect_obs("readback", MRb, {rb[15-i], 3'b011});
      bus.cfg_en = 1'b1;
      bus.cfg_in = 1'b0;
      tick();
    end
    bus.cfg_en = 1'b0;
    expect_obs("readback_done", MRb, 4'b0011);
    tick();

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
